// File: rtl/deadlock_block_reporter_if.sv
// Bundle of the monitor-side block flags, the clear acknowledge and the report handshake.
// The master drives stimulus and acknowledges; the slave is the reporter block.
interface deadlock_block_reporter_if #(
  parameter int NUM_MON = 4,
  parameter int IDX_W   = 5,
  parameter int CNT_W   = 16
);
  logic [NUM_MON-1:0] block_in;
  logic               clear;
  logic               report_ready;
  logic               deadlock;
  logic               report_valid;
  logic [IDX_W-1:0]   report_idx;
  logic [NUM_MON-1:0] report_mask;
  logic [CNT_W-1:0]   blocked_cycles;

  modport master (
    output block_in, clear, report_ready,
    input  deadlock, report_valid, report_idx, report_mask, blocked_cycles
  );

  modport slave (
    input  block_in, clear, report_ready,
    output deadlock, report_valid, report_idx, report_mask, blocked_cycles
  );
endinterface

// File: rtl/deadlock_block_reporter.sv
// Declares a deadlock once any monitor has been blocked for TIMEOUT consecutive cycles,
// then holds a one-shot report (lowest blocked index plus mask) until it is consumed.
module deadlock_block_reporter #(
  parameter int NUM_MON = 4,
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 16,
  parameter int IDX_W   = 5
) (
  input  logic                        clock,
  input  logic                        reset,
  deadlock_block_reporter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, COUNTING, REPORT, HALT} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_MON-1:0] mask_q, mask_d;
  logic               deadlock_q, deadlock_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   low_idx;
  logic               any_block;

  assign any_block = |bus.block_in;

  // Descending scan so the last hit written is the lowest set bit.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (bus.block_in[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    // NOTE: every _d starts from its held value, so no path through this block infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    mask_d     = mask_q;
    deadlock_d = deadlock_q;
    valid_d    = valid_q;
    if (bus.clear) begin
      state_d    = IDLE;
      cnt_d      = '0;
      idx_d      = '0;
      mask_d     = '0;
      deadlock_d = 1'b0;
      valid_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_block) begin
            state_d = COUNTING;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d   = '0;
          end
        end
        COUNTING: begin
          if (!any_block) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == LAST_C) begin
            // Counter parks at TIMEOUT; the snapshot is frozen until clear or reset.
            state_d    = REPORT;
            cnt_d      = TIMEOUT_C;
            mask_d     = bus.block_in;
            idx_d      = low_idx;
            deadlock_d = 1'b1;
            valid_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REPORT: begin
          if (bus.report_ready) begin
            state_d = HALT;
            valid_d = 1'b0;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state uses <= so every flop samples the pre-edge values of its neighbours.
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      mask_q     <= '0;
      deadlock_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      mask_q     <= mask_d;
      deadlock_q <= deadlock_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.deadlock       = deadlock_q;
  assign bus.report_valid   = valid_q;
  assign bus.report_idx     = idx_q;
  assign bus.report_mask    = mask_q;
  assign bus.blocked_cycles = cnt_q;

endmodule
